multi_led_pattern_gen: RTL and testbench

Multi-channel LED driver and the parametrised successor to the single fixed-rate blinker. Each of NUM_CH outputs runs in its own mode: OFF, ON, BLINK or PWM with 2^PWM_BITS duty steps. Channels are configured at run time through a valid/ready port. Configuration changes take effect only at a PWM frame boundary, so outputs are glitch-free. The block sits between top-level control logic, or static tie-offs, and the board LED pins.

---
 rtl/multi_led_pattern_gen_if.sv | 24 ++
 rtl/multi_led_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_multi_led_pattern_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multi_led_pattern_gen_if.sv
// Channel configuration port: one {ch, mode, duty} word per valid/ready transfer.
// Master holds the word stable while cfg_ready is low.
interface multi_led_pattern_gen_if #(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/multi_led_pattern_gen.sv
// Multi-channel LED driver (OFF/ON/BLINK/PWM), config applied only at PWM frame boundaries.
// led is registered (1 cycle after counter state); one pending config slot, cfg_ready low while it is full.
module multi_led_pattern_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_CH      = 4,
  parameter int PWM_BITS    = 8,
  parameter int PWM_FREQ_HZ = 1000,
  parameter int BLINK_HZ    = 2
) (
  input  logic                      clk,
  input  logic                      rst_async,
  multi_led_pattern_gen_if.slave    cfg,
  output logic [NUM_CH-1:0]         led,
  output logic                      frame_tick
);

  localparam int PRESC      = CLK_FREQ_HZ / (PWM_FREQ_HZ * (2 ** PWM_BITS));
  localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PC_W       = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int BC_W       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  generate
    if (PRESC < 1 || BLINK_HALF < 1 || NUM_CH < 1) begin : g_bad_params
      $error("multi_led_pattern_gen: PRESC, BLINK_HALF and NUM_CH must all be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    led_mode_e           mode;
    logic [PWM_BITS-1:0] duty;
  } cfg_word_t;

  // Reset: asserts asynchronously, releases on the 2nd clk edge after rst_async falls.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) rst_sync <= 2'b11;
    else           rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_i = rst_sync[1];

  logic [PC_W-1:0]     presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BC_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic                presc_wrap;

  assign presc_wrap = (presc_cnt == PC_W'(PRESC - 1));
  assign frame_tick = !rst_i && presc_wrap && (pwm_cnt == '1);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (presc_wrap) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      end else begin
        presc_cnt <= presc_cnt + PC_W'(1);
      end
      // Blink runs free of the PWM frame.
      if (blink_cnt == BC_W'(BLINK_HALF - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  cfg_word_t pend_q;
  logic      pend_vld;
  logic      accept;
  logic      commit;

  assign cfg.cfg_ready = !rst_i && !pend_vld;
  // Out-of-range channel words are consumed and dropped.
  assign accept = cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_ch) < NUM_CH);
  assign commit = pend_vld && frame_tick;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pend_vld <= 1'b0;
      pend_q   <= '0;
    end else if (accept) begin
      pend_vld <= 1'b1;
      pend_q   <= '{ch: cfg.cfg_ch, mode: led_mode_e'(cfg.cfg_mode), duty: cfg.cfg_duty};
    end else if (commit) begin
      pend_vld <= 1'b0;
    end
  end

  led_mode_e           mode_q [NUM_CH];
  logic [PWM_BITS-1:0] duty_q [NUM_CH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pend_q.ch == CH_W'(i)) begin
          mode_q[i] <= pend_q.mode;
          duty_q[i] <= pend_q.duty;
        end
      end
    end
  end

  logic [NUM_CH-1:0] led_nxt;

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode_q[i])
        MODE_OFF:   led_nxt[i] = 1'b0;
        MODE_ON:    led_nxt[i] = 1'b1;
        MODE_BLINK: led_nxt[i] = blink_phase;
        MODE_PWM:   led_nxt[i] = (pwm_cnt < duty_q[i]);
        default:    led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) led <= '0;
    else       led <= led_nxt;
  end

endmodule

// File: tb/tb_multi_led_pattern_gen.sv
// Directed bench: 4-channel and 3-channel builds at PRESC=4 (64-cycle frame), BLINK_HALF=32.
// cyc counts negedges since the internal reset released; frame phase is cyc % 64.
module tb_multi_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_async;
  logic [3:0] a_led;
  logic       a_ft;
  logic [2:0] b_led;
  logic       b_ft;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  multi_led_pattern_gen_if #(.NUM_CH(4), .PWM_BITS(4)) a_if ();
  multi_led_pattern_gen_if #(.NUM_CH(3), .PWM_BITS(4)) b_if ();

  multi_led_pattern_gen #(
    .CLK_FREQ_HZ(6400), .NUM_CH(4), .PWM_BITS(4), .PWM_FREQ_HZ(100), .BLINK_HZ(100)
  ) dut_a (
    .clk(clk), .rst_async(rst_async), .cfg(a_if.slave), .led(a_led), .frame_tick(a_ft)
  );

  multi_led_pattern_gen #(
    .CLK_FREQ_HZ(6400), .NUM_CH(3), .PWM_BITS(4), .PWM_FREQ_HZ(100), .BLINK_HZ(100)
  ) dut_b (
    .clk(clk), .rst_async(rst_async), .cfg(b_if.slave), .led(b_led), .frame_tick(b_ft)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_phase(input int p);
    do step(); while (cyc % 64 != p);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  int         ones;
  int         rises;
  logic       prev;
  logic [3:0] s_led;
  logic [3:0] or_led;
  int         tick_at;

  initial begin
    rst_async      = 1'b1;
    a_if.cfg_valid = 1'b0; a_if.cfg_ch = '0; a_if.cfg_mode = 2'd0; a_if.cfg_duty = '0;
    b_if.cfg_valid = 1'b0; b_if.cfg_ch = '0; b_if.cfg_mode = 2'd0; b_if.cfg_duty = '0;

    // 1. Reset and synchroniser release
    repeat (5) step();
    chk("rst_led",     32'(a_led), 0);
    chk("rst_ready",   32'(a_if.cfg_ready), 0);
    chk("rst_tick",    32'(a_ft), 0);
    chk("rst_b_ready", 32'(b_if.cfg_ready), 0);
    rst_async = 1'b0;
    step();
    chk("sync_edge1_ready", 32'(a_if.cfg_ready), 0);
    step();
    chk("sync_edge2_ready", 32'(a_if.cfg_ready), 1);
    cyc = 0;
    while (!a_ft && cyc < 200) step();
    chk("first_tick_cycle", 32'(cyc), 63);

    // 2. PWM ch0 duty 4
    goto_phase(0);
    a_if.cfg_valid = 1'b1; a_if.cfg_ch = 2'd0; a_if.cfg_mode = 2'd3; a_if.cfg_duty = 4'd4;
    step();
    a_if.cfg_valid = 1'b0;
    chk("pwm_pending_busy", 32'(a_if.cfg_ready), 0);
    goto_phase(63);
    chk("pwm_tick", 32'(a_ft), 1);
    chk("pwm_busy_at_tick", 32'(a_if.cfg_ready), 0);
    step();
    chk("pwm_ready_back", 32'(a_if.cfg_ready), 1);
    chk("pwm_led_before", 32'(a_led[0]), 0);
    ones = 0; rises = 0; prev = a_led[0];
    for (int i = 0; i < 64; i++) begin
      step();
      ones += int'(a_led[0]);
      if (a_led[0] && !prev) rises++;
      prev = a_led[0];
      if (i == 0)  chk("pwm_first_high", 32'(a_led[0]), 1);
      if (i == 15) chk("pwm_last_high",  32'(a_led[0]), 1);
      if (i == 16) chk("pwm_first_low",  32'(a_led[0]), 0);
    end
    chk("pwm_high_count", 32'(ones), 16);
    chk("pwm_one_pulse",  32'(rises), 1);
    chk("pwm_others_off", 32'(a_led[3:1]), 0);

    // 3. BLINK ch1 (cyc is 192, frame phase 0)
    a_if.cfg_valid = 1'b1; a_if.cfg_ch = 2'd1; a_if.cfg_mode = 2'd2; a_if.cfg_duty = 4'd0;
    step();
    a_if.cfg_valid = 1'b0;
    goto_phase(63);
    step();
    goto_cyc(288);
    chk("blink_low_288",  32'(a_led[1]), 0);
    step();
    chk("blink_high_289", 32'(a_led[1]), 1);
    chk("blink_pwm0_289", 32'(a_led[0]), 0);
    goto_cyc(320);
    chk("blink_high_320", 32'(a_led[1]), 1);
    step();
    chk("blink_low_321",  32'(a_led[1]), 0);
    chk("blink_pwm0_321", 32'(a_led[0]), 1);
    chk("blink_ch23_off", 32'(a_led[3:2]), 0);

    // 4. Backpressure: ch2 ON, then ch3 ON held while the slot is full
    goto_phase(0);
    a_if.cfg_valid = 1'b1; a_if.cfg_ch = 2'd2; a_if.cfg_mode = 2'd1;
    step();
    a_if.cfg_ch = 2'd3;
    chk("bp_stall", 32'(a_if.cfg_ready), 0);
    goto_phase(63);
    chk("bp_stall_at_tick", 32'(a_if.cfg_ready), 0);
    step();
    chk("bp_ready_after_tick", 32'(a_if.cfg_ready), 1);
    chk("bp_led2_before", 32'(a_led[2]), 0);
    step();
    a_if.cfg_valid = 1'b0;
    chk("bp_ch3_taken", 32'(a_if.cfg_ready), 0);
    chk("bp_led2_on", 32'(a_led[2]), 1);
    goto_cyc(512);
    chk("bp_led3_before", 32'(a_led[3]), 0);
    step();
    chk("bp_led3_on", 32'(a_led[3]), 1);

    // 5. Invalid channel on the 3-channel build
    b_if.cfg_valid = 1'b1; b_if.cfg_ch = 2'd3; b_if.cfg_mode = 2'd1; b_if.cfg_duty = 4'd0;
    step();
    chk("inv_ready_kept", 32'(b_if.cfg_ready), 1);
    goto_phase(63);
    chk("inv_b_tick", 32'(b_ft), 1);
    chk("inv_ready_at_tick", 32'(b_if.cfg_ready), 1);
    step();
    b_if.cfg_valid = 1'b0;
    step();
    chk("inv_no_led", 32'(b_led), 0);
    chk("inv_ready_after", 32'(b_if.cfg_ready), 1);

    // 6. Mid-frame reset with a config still pending
    goto_phase(0);
    a_if.cfg_valid = 1'b1; a_if.cfg_ch = 2'd0; a_if.cfg_mode = 2'd1;
    step();
    a_if.cfg_valid = 1'b0;
    goto_phase(63);
    step();
    goto_phase(2);
    a_if.cfg_valid = 1'b1; a_if.cfg_ch = 2'd1; a_if.cfg_mode = 2'd2;
    step();
    a_if.cfg_valid = 1'b0;
    goto_phase(20);
    chk("mid_led0_on", 32'(a_led[0]), 1);
    chk("mid_pending", 32'(a_if.cfg_ready), 0);
    rst_async = 1'b1;
    #1;
    s_led = a_led;
    chk("mid_rst_led_now", 32'(s_led), 0);
    chk("mid_rst_ready",   32'(a_if.cfg_ready), 0);
    chk("mid_rst_tick",    32'(a_ft), 0);
    repeat (3) step();
    rst_async = 1'b0;
    step();
    step();
    chk("mid_release_ready", 32'(a_if.cfg_ready), 1);
    cyc = 0; or_led = '0; tick_at = -1;
    for (int i = 0; i < 70; i++) begin
      step();
      or_led |= a_led;
      if (a_ft && tick_at < 0) tick_at = cyc;
    end
    chk("post_rst_all_off", 32'(or_led), 0);
    chk("post_rst_tick", 32'(tick_at), 63);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
